// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - shared types and helpers for the match timer controller
package game_timer_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, TIME_UP} timer_state_t;

  // Prescaler width; a one-tick-per-cycle time base still needs a 1-bit register.
  function automatic int tick_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-second time base prescaler with clear and freeze
module sec_tick_gen
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int              W    = tick_width(TICKS_PER_SEC);
  localparam logic [W-1:0]    LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt;

  // The tick cycle is also the wrap cycle; when run is low the count is frozen.
  assign tick = run & (cnt == LAST);

  // Prescaler: cleared on match load, advances only while run is asserted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - start/pause/time-up controller for the two-digit match timer
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int         TICKS_PER_SEC = 50_000_000,
  parameter logic [3:0] ONES_INIT     = 4'd0,
  parameter logic [3:0] TENS_INIT     = 4'd6
) (
  input  logic clk,
  input  logic resetN,
  input  logic startN,
  input  logic tc_ones,
  input  logic tc_tens,
  output logic ena_ones,
  output logic ena_tens,
  output logic loadN,
  output logic running,
  output logic time_up
);

  // The preset digits reach the counters' datain outside this block; they are
  // kept here so one parameter set describes the whole timer.
  localparam logic [7:0] unused_init_digits = {TENS_INIT, ONES_INIT};

  timer_state_t state;
  logic         startN_d;
  logic         press;
  logic         both_tc;
  logic         tick;

  assign press   = startN_d & ~startN;
  assign both_tc = tc_ones & tc_tens;

  // Key history for falling-edge detection; idle key level is high.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      startN_d <= 1'b1;
    end else begin
      startN_d <= startN;
    end
  end

  // A press in RUN freezes the prescaler so a coincident tick is deferred to resume.
  sec_tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk   (clk),
    .resetN(resetN),
    .clear (state == LOAD),
    .run   ((state == RUN) && !press),
    .tick  (tick)
  );

  // Enables never fire at 00, so the counters cannot wrap to 99.
  assign ena_ones = (state == RUN) & ~both_tc & tick;
  assign ena_tens = ena_ones & tc_ones;

  // Match state machine with its status outputs registered alongside the state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      loadN   <= 1'b1;
      running <= 1'b0;
      time_up <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state <= LOAD;
            loadN <= 1'b0;
          end
        end
        LOAD: begin
          state   <= RUN;
          loadN   <= 1'b1;
          running <= 1'b1;
        end
        RUN: begin
          if (both_tc) begin
            state   <= TIME_UP;
            running <= 1'b0;
            time_up <= 1'b1;
          end else if (press) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        TIME_UP: begin
          if (press) begin
            state   <= LOAD;
            loadN   <= 1'b0;
            time_up <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          loadN   <= 1'b1;
          running <= 1'b0;
          time_up <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb/tb_game_timer_ctrl.sv - self-checking bench for game_timer_ctrl with real digit counters
module tb_game_timer_ctrl;

  localparam int TPS = 4;
  localparam logic [3:0] INIT_O [2] = '{4'd2, 4'd0};
  localparam logic [3:0] INIT_T [2] = '{4'd1, 4'd0};
  localparam int         INIT_S [2] = '{12, 0};

  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_UP = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic [1:0] sn, tco, tct, eo, et, ld, rn, tu;
  logic [3:0] ones [2];
  logic [3:0] tens [2];

  int n_tests = 0;
  int n_fail  = 0;

  int   m_state [2];
  int   m_phase [2];
  int   m_secs  [2];
  logic m_prev  [2];

  always #5 clk = ~clk;

  game_timer_ctrl #(.TICKS_PER_SEC(TPS), .ONES_INIT(INIT_O[0]), .TENS_INIT(INIT_T[0])) dut_a (
    .clk(clk), .resetN(resetN), .startN(sn[0]), .tc_ones(tco[0]), .tc_tens(tct[0]),
    .ena_ones(eo[0]), .ena_tens(et[0]), .loadN(ld[0]), .running(rn[0]), .time_up(tu[0]));

  game_timer_ctrl #(.TICKS_PER_SEC(TPS), .ONES_INIT(INIT_O[1]), .TENS_INIT(INIT_T[1])) dut_b (
    .clk(clk), .resetN(resetN), .startN(sn[1]), .tc_ones(tco[1]), .tc_tens(tct[1]),
    .ena_ones(eo[1]), .ena_tens(et[1]), .loadN(ld[1]), .running(rn[1]), .time_up(tu[1]));

  // Two cascaded 9-to-0 BCD down counters per timer: load, enable, terminal count.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        ones[i] <= 4'd0;
        tens[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!ld[i]) begin
          ones[i] <= INIT_O[i];
          tens[i] <= INIT_T[i];
        end else begin
          if (eo[i]) ones[i] <= (ones[i] == 4'd0) ? 4'd9 : ones[i] - 4'd1;
          if (et[i]) tens[i] <= (tens[i] == 4'd0) ? 4'd9 : tens[i] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    tco = '0;
    tct = '0;
    for (int i = 0; i < 2; i++) begin
      tco[i] = (ones[i] == 4'd0);
      tct[i] = (tens[i] == 4'd0);
    end
  end

  // Reference: seconds remaining as an integer, phase within the current second.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] <= M_IDLE;
        m_phase[i] <= 0;
        m_secs[i]  <= 0;
        m_prev[i]  <= 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_state[i])
          M_IDLE:  if (m_prev[i] && !sn[i]) m_state[i] <= M_LOAD;
          M_LOAD: begin
            m_state[i] <= M_RUN;
            m_phase[i] <= 0;
            m_secs[i]  <= INIT_S[i];
          end
          M_RUN: begin
            if (m_secs[i] == 0) m_state[i] <= M_UP;
            else if (m_prev[i] && !sn[i]) m_state[i] <= M_PAUSE;
            else if (m_phase[i] == TPS - 1) begin
              m_secs[i]  <= m_secs[i] - 1;
              m_phase[i] <= 0;
            end else m_phase[i] <= m_phase[i] + 1;
          end
          M_PAUSE: if (m_prev[i] && !sn[i]) m_state[i] <= M_RUN;
          default: if (m_prev[i] && !sn[i]) m_state[i] <= M_LOAD;
        endcase
        m_prev[i] <= sn[i];
      end
    end
  end

  function automatic logic [12:0] exp_vec(input int i);
    logic pr, e1;
    pr = m_prev[i] & ~sn[i];
    e1 = (m_state[i] == M_RUN) && (m_secs[i] != 0) && !pr && (m_phase[i] == TPS - 1);
    return {m_state[i] != M_LOAD, m_state[i] == M_RUN, m_state[i] == M_UP,
            e1, e1 && (m_secs[i] % 10 == 0), 4'(m_secs[i] / 10), 4'(m_secs[i] % 10)};
  endfunction

  function automatic logic [12:0] obs_vec(input int i);
    return {ld[i], rn[i], tu[i], eo[i], et[i], tens[i], ones[i]};
  endfunction

  task automatic test_reset;
    sn = 2'b11;
    resetN = 1'b1;
    #2 resetN = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_tests++;
      if ({ld, rn, tu, eo, et} !== 10'b11_00_00_00_00) begin
        n_fail++;
        $display("FAIL reset_idle t=%0t got=%b want=%b", $time, {ld, rn, tu, eo, et}, 10'b11_00_00_00_00);
      end
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL reset_model dut%0d t=%0t got=%h want=%h", j, $time, obs_vec(j), exp_vec(j));
        end
      end
    end
  endtask

  task automatic test_countdown;
    int ld_cnt = 0;
    int up_k = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL countdown dut%0d k=%0d got=%h want=%h", j, k, obs_vec(j), exp_vec(j));
        end
      end
      if (!ld[0]) ld_cnt++;
      if (tu[0] && up_k < 0) up_k = k;
      if (k == 0) sn[0] = 1'b0;
      if (k == 1) sn[0] = 1'b1;
    end
    n_tests++;
    if (ld_cnt != 1) begin
      n_fail++;
      $display("FAIL countdown_load_pulses got=%0d want=1", ld_cnt);
    end
    n_tests++;
    if (up_k != 2 + 12 * TPS + 1) begin
      n_fail++;
      $display("FAIL countdown_time_up_cycle got=%0d want=%0d", up_k, 2 + 12 * TPS + 1);
    end
    n_tests++;
    if ({tens[0], ones[0], tu[0]} !== 9'b0000_0000_1) begin
      n_fail++;
      $display("FAIL countdown_final got=%b want=%b", {tens[0], ones[0], tu[0]}, 9'b0000_0000_1);
    end
  endtask

  task automatic test_pause;
    int found = 0;
    int gap = 0;
    logic [7:0] frozen;
    @(negedge clk);
    sn[0] = 1'b0;
    @(negedge clk);
    sn[0] = 1'b1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL pause_run dut%0d k=%0d got=%h want=%h", j, k, obs_vec(j), exp_vec(j));
        end
      end
      if (m_state[0] == M_RUN && m_phase[0] == 1 && m_secs[0] < INIT_S[0] && m_secs[0] > 2) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL pause_find_slot got=timeout want=slot");
    end
    frozen = {4'(m_secs[0] / 10), 4'(m_secs[0] % 10)};
    sn[0] = 1'b0;
    @(negedge clk);
    sn[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      n_tests++;
      if ({rn[0], eo[0], tens[0], ones[0]} !== {2'b00, frozen}) begin
        n_fail++;
        $display("FAIL pause_frozen k=%0d got=%h want=%h", k, {rn[0], eo[0], tens[0], ones[0]}, {2'b00, frozen});
      end
      @(negedge clk);
    end
    sn[0] = 1'b0;
    @(negedge clk);
    sn[0] = 1'b1;
    while (!eo[0] && gap < 10) begin
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL pause_resume dut%0d got=%h want=%h", j, obs_vec(j), exp_vec(j));
        end
      end
      @(negedge clk);
      gap++;
    end
    n_tests++;
    if (gap != 2) begin
      n_fail++;
      $display("FAIL pause_resume_gap got=%0d want=2", gap);
    end
  endtask

  task automatic test_tick_press;
    int found = 0;
    int s;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL tickpress_run dut%0d k=%0d got=%h want=%h", j, k, obs_vec(j), exp_vec(j));
        end
      end
      if (m_state[0] == M_RUN && m_phase[0] == TPS - 1 && m_secs[0] > 1) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL tickpress_find_tick got=timeout want=tick");
    end
    s = m_secs[0];
    sn[0] = 1'b0;
    @(negedge clk);
    sn[0] = 1'b1;
    n_tests++;
    if ({rn[0], tens[0], ones[0]} !== {1'b0, 4'(s / 10), 4'(s % 10)}) begin
      n_fail++;
      $display("FAIL tickpress_no_decrement got=%h want=%h", {rn[0], tens[0], ones[0]}, {1'b0, 4'(s / 10), 4'(s % 10)});
    end
    repeat (5) @(negedge clk);
    sn[0] = 1'b0;
    @(negedge clk);
    sn[0] = 1'b1;
    n_tests++;
    if ({rn[0], eo[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL tickpress_resume_tick got=%b want=11", {rn[0], eo[0]});
    end
    for (int j = 0; j < 2; j++) begin
      n_tests++;
      if (obs_vec(j) !== exp_vec(j)) begin
        n_fail++;
        $display("FAIL tickpress_resume dut%0d got=%h want=%h", j, obs_vec(j), exp_vec(j));
      end
    end
  endtask

  task automatic test_zero_init;
    for (int r = 0; r < 2; r++) begin
      int run_cnt = 0;
      int ena_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
          n_tests++;
          if (obs_vec(j) !== exp_vec(j)) begin
            n_fail++;
            $display("FAIL zero_init dut%0d r=%0d k=%0d got=%h want=%h", j, r, k, obs_vec(j), exp_vec(j));
          end
        end
        if (rn[1]) run_cnt++;
        if (eo[1] || et[1]) ena_cnt++;
        sn[1] = (k == 0) ? 1'b0 : 1'b1;
      end
      n_tests++;
      if ({run_cnt, ena_cnt} !== {32'd1, 32'd0} || tu[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_init_summary r=%0d got run=%0d ena=%0d up=%b want run=1 ena=0 up=1", r, run_cnt, ena_cnt, tu[1]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    n_tests++;
    if (rn[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_precondition got=%b want=1", rn[0]);
    end
    #1 resetN = 1'b0;
    #1;
    n_tests++;
    if ({ld, rn, tu, eo, et} !== 10'b11_00_00_00_00) begin
      n_fail++;
      $display("FAIL midrun_async_reset got=%b want=%b", {ld, rn, tu, eo, et}, 10'b11_00_00_00_00);
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL midrun_after dut%0d k=%0d got=%h want=%h", j, k, obs_vec(j), exp_vec(j));
        end
      end
    end
  endtask

  task automatic test_hold_key;
    int ld_cnt = 0;
    for (int k = 0; k < 101; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL hold_key dut%0d k=%0d got=%h want=%h", j, k, obs_vec(j), exp_vec(j));
        end
      end
      if (!ld[0]) ld_cnt++;
      sn[0] = (k < 100) ? 1'b0 : 1'b1;
    end
    n_tests++;
    if (ld_cnt != 1 || tu[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_key_single_press got loads=%0d up=%b want loads=1 up=1", ld_cnt, tu[0]);
    end
  endtask

  task automatic test_random;
    int left [2] = '{3, 7};
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        n_tests++;
        if (obs_vec(j) !== exp_vec(j)) begin
          n_fail++;
          $display("FAIL random dut%0d k=%0d got=%h want=%h", j, k, obs_vec(j), exp_vec(j));
        end
        left[j]--;
        if (left[j] <= 0) begin
          sn[j] = ~sn[j];
          left[j] = sn[j] ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 6));
        end
      end
    end
    sn = 2'b11;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_tick_press();
    test_zero_init();
    test_reset_mid_run();
    test_hold_key();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
